sipo_rx_ctrl: RTL and testbench
===============================

# sipo_rx_ctrl

Frame-level receive controller that sequences a serial-in/parallel-out shift datapath. It detects a start bit and shifts exactly WIDTH data bits LSB-first into an internal SIPO register. It then checks the stop bit and presents the assembled word on a valid/ready parallel output port with a one-word holding buffer. It sits between a bit-strobed serial source and any parallel consumer, and reports framing and overrun errors.

## Interface
- WIDTH, 4: data bits per frame; legal range 2..16.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- ser_in  input  1  serial data; sampled only when ser_en=1.
- ser_en  input  1  bit strobe; one serial bit per cycle with ser_en=1.
- out_data  output  WIDTH  received word; LSB = first data bit received.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- busy  output  1  high while a frame is in progress (state != IDLE).
- frame_err  output  1  sticky; stop bit sampled as 0.
- overrun  output  1  sticky; good frame completed while the buffer was full.
- clr_err  input  1  clears frame_err and overrun; lower priority than setting.

## Operation
- State machine: IDLE, SHIFT, STOP.
- IDLE: ser_en && !ser_in (start bit) -> SHIFT, bit counter := 0. ser_en && ser_in (line idle) -> stay in IDLE.
- SHIFT: on each ser_en, shreg := {ser_in, shreg[WIDTH-1:1]} and cnt := cnt+1. On the ser_en where cnt == WIDTH-1, go to STOP. Cycles without ser_en hold all state.
- STOP, on ser_en:
  - ser_in=1 with the buffer free, or freed this same cycle (out_valid && out_ready): out_data := shreg, out_valid := 1.
  - ser_in=1 with the buffer full and not consumed: word dropped, overrun := 1, out_data unchanged.
  - ser_in=0: word dropped, frame_err := 1.
  - In all three cases, go to IDLE.
- Handshake: out_valid clears on out_valid && out_ready unless a new word loads in the same cycle. In that case out_data takes the new word and out_valid stays 1. out_data is stable while out_valid=1 and not accepted.
- Counter width: $clog2(WIDTH) bits; no wrap-around beyond WIDTH-1.
- Error flags: set wins over clr_err in the same cycle. Errors do not block reception of later frames.
- busy = (state != IDLE).

## Timing
- Reset values: state=IDLE, shreg=0, cnt=0, out_data=0, out_valid=0, busy=0, frame_err=0, overrun=0.
- A frame is 1 start + WIDTH data + 1 stop bits = WIDTH+2 strobes.
- out_valid rises the cycle after the edge that samples the stop bit. Latency is 1 clk from the stop strobe.
- busy rises the cycle after the start-bit edge and falls the cycle after the stop-bit edge.
- Back-to-back frames: a start bit may arrive on the strobe right after the stop strobe, with ser_en continuously high. No dead cycle is required.
- Reset asserted mid-frame: the partial word is discarded and all outputs take their reset values on the next edge. A buffered word is also discarded.
- ser_en=0 for any number of cycles mid-frame: state is frozen, no timeout.

## Test plan
- Basic frame (WIDTH=4, out_ready=1): ser_en=1 every cycle; ser_in sequence 0,1,0,1,1,1.
  - Response: out_data=4'hD, out_valid=1 for exactly 1 cycle. out_valid rises 1 cycle after the stop bit. busy high for 5 cycles. Both error flags stay 0.
- Gapped strobe: same frame, ser_en high every 3rd cycle.
  - Response: out_data=4'hD. Shift and count advance only on strobes.
- Framing error: sequence 0,0,0,1,1,0.
  - Response: out_valid stays 0, frame_err=1 and sticky. A following good frame of 0xA delivers 4'hA.
  - Pulse clr_err -> frame_err=0.
- Overrun and simultaneous accept:
  - out_ready=0; send 0x3, then 0x5. Response: out_data stays 4'h3, overrun=1.
  - Repeat with out_ready=1 asserted in the cycle of the second stop strobe. Response: out_data=4'h5, out_valid stays 1, no overrun.
- Reset mid-frame: rst=1 after 2 data bits.
  - Response: next cycle busy=0, out_valid=0, flags 0. A following frame 0x9 delivers 4'h9 with no stale bits.
- Back-to-back: two frames (0x1, 0xE) with no idle strobe between them, out_ready=1.
  - Response: two single-cycle out_valid pulses, 6 cycles apart, carrying 4'h1 then 4'hE.

Source files
------------

// File: rtl/sipo_rx_ctrl.sv
// sipo_rx_ctrl: start/stop framed serial receiver with SIPO shift register
// and a one-word valid/ready output buffer; flags framing and overrun errors.
module sipo_rx_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ser_in,
   input  logic             ser_en,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun,
   input  logic             clr_err
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      STOP  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [WIDTH-1:0] data_n;
   logic             valid_n, ferr_n, ovr_n;
   logic             accept;

   assign accept = out_valid && out_ready;
   assign busy   = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         shreg     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         shreg     <= shreg_n;
         out_data  <= data_n;
         out_valid <= valid_n;
         frame_err <= ferr_n;
         overrun   <= ovr_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      shreg_n = shreg;
      data_n  = out_data;
      valid_n = out_valid && !accept;
      ferr_n  = frame_err && !clr_err;
      ovr_n   = overrun && !clr_err;
      unique case (state)
         IDLE: begin
            if (ser_en && !ser_in) begin
               state_n = SHIFT;
               cnt_n   = '0;
            end
         end
         SHIFT: begin
            if (ser_en) begin
               shreg_n = {ser_in, shreg[WIDTH-1:1]};
               // Counter saturates at the last data bit instead of wrapping
               if (cnt == LAST) begin
                  state_n = STOP;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         STOP: begin
            if (ser_en) begin
               state_n = IDLE;
               unique case (1'b1)
                  (ser_in && (!out_valid || out_ready)): begin
                     data_n  = shreg;
                     valid_n = 1'b1;
                  end
                  (ser_in && out_valid && !out_ready): begin
                     ovr_n = 1'b1;
                  end
                  (!ser_in): begin
                     ferr_n = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// tb_sipo_rx_ctrl: directed frames checked against a frame-level model
// every cycle, plus literal expectations for key scenarios.
module tb_sipo_rx_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ser_in = 1'b1;
   logic         ser_en = 1'b0;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic         busy;
   logic         frame_err;
   logic         overrun;
   logic         clr_err = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit run = 1'b0;

   sipo_rx_ctrl #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .ser_in(ser_in),
      .ser_en(ser_en),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy(busy),
      .frame_err(frame_err),
      .overrun(overrun),
      .clr_err(clr_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      int          nb;
      logic [15:0] w;
      logic [15:0] d;
      logic        v;
      logic        fe;
      logic        ov;
   } mdl_t;

   mdl_t m;

   // nb counts frame bits taken so far (start included); 0 means idle
   function automatic mdl_t mdl_next(mdl_t s, logic r, logic en,
                                     logic in, logic rdy, logic clr);
      mdl_t n;
      n = s;
      if (r) begin
         n = '0;
         return n;
      end
      n.v  = s.v && !rdy;
      n.fe = s.fe && !clr;
      n.ov = s.ov && !clr;
      if (en) begin
         if (s.nb == 0) begin
            if (!in) n.nb = 1;
         end else if (s.nb <= W) begin
            n.w[s.nb-1] = in;
            n.nb = s.nb + 1;
         end else begin
            n.nb = 0;
            if (!in) n.fe = 1'b1;
            else if (!s.v || rdy) begin
               n.d = {12'h000, s.w[W-1:0]};
               n.v = 1'b1;
            end else n.ov = 1'b1;
         end
      end
      return n;
   endfunction

   always @(posedge clk)
      m <= mdl_next(m, rst, ser_en, ser_in, out_ready, clr_err);

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d act=%0h exp=%0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (run) begin
         chk("busy", 32'(busy), 32'(m.nb != 0));
         chk("valid", 32'(out_valid), 32'(m.v));
         chk("data", 32'(out_data), 32'(m.d[W-1:0]));
         chk("ferr", 32'(frame_err), 32'(m.fe));
         chk("ovr", 32'(overrun), 32'(m.ov));
      end
   end

   task automatic step(logic en, logic in);
      ser_en = en;
      ser_in = in;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic frame(logic [W-1:0] w, logic stopb);
      step(1'b1, 1'b0);
      for (int i = 0; i < W; i++) step(1'b1, w[i]);
      step(1'b1, stopb);
   endtask

   initial begin
      int bcnt;
      int vcnt;
      int qc[$];
      logic [W-1:0] qd[$];
      logic [W-1:0] b2b;
      logic [11:0] bits;

      rst = 1'b1;
      repeat (2) @(negedge clk);
      run = 1'b1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_flags", 32'({frame_err, overrun}), 0);
      rst = 1'b0;
      step(1'b0, 1'b1);

      // Basic frame 0xD: 0,1,0,1,1,1
      bits = 12'b0000_0011_1010;
      bcnt = 0;
      vcnt = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, bits[i]);
         if (busy) bcnt++;
         if (out_valid) vcnt++;
         if (i == 5) begin
            chk("basic_data", 32'(out_data), 32'hD);
            chk("basic_model", 32'(m.d[W-1:0]), 32'hD);
            chk("basic_valid", 32'(out_valid), 1);
         end
      end
      step(1'b1, 1'b1);
      if (out_valid) vcnt++;
      chk("basic_busy_cyc", 32'(bcnt), 5);
      chk("basic_valid_cyc", 32'(vcnt), 1);
      chk("basic_flags", 32'({frame_err, overrun}), 0);

      // Gapped strobes, every third cycle
      for (int i = 0; i < 6; i++) begin
         step(1'b1, bits[i]);
         if (i == 5) chk("gap_data", 32'(out_data), 32'hD);
         step(1'b0, 1'b0);
         step(1'b0, 1'b1);
         if (i == 2) chk("gap_busy", 32'(busy), 1);
      end

      // Framing error, then good 0xA, then clear
      frame(4'b1100, 1'b0);
      chk("fe_valid", 32'(out_valid), 0);
      chk("fe_set", 32'(frame_err), 1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      chk("fe_sticky", 32'(frame_err), 1);
      frame(4'hA, 1'b1);
      chk("fe_next_data", 32'(out_data), 32'hA);
      chk("fe_next_model", 32'(m.d[W-1:0]), 32'hA);
      clr_err = 1'b1;
      step(1'b0, 1'b1);
      clr_err = 1'b0;
      chk("fe_clr", 32'(frame_err), 0);

      // Overrun with consumer stalled
      out_ready = 1'b0;
      frame(4'h3, 1'b1);
      frame(4'h5, 1'b1);
      chk("ovr_data", 32'(out_data), 32'h3);
      chk("ovr_flag", 32'(overrun), 1);
      chk("ovr_model", 32'(m.ov), 1);
      out_ready = 1'b1;
      clr_err = 1'b1;
      step(1'b0, 1'b1);
      clr_err = 1'b0;
      out_ready = 1'b0;

      // Second stop strobe coincides with accept
      frame(4'h3, 1'b1);
      step(1'b1, 1'b0);
      for (int i = 0; i < W; i++) step(1'b1, 1'(i == 0 || i == 2));
      out_ready = 1'b1;
      step(1'b1, 1'b1);
      out_ready = 1'b0;
      chk("acc_data", 32'(out_data), 32'h5);
      chk("acc_valid", 32'(out_valid), 1);
      chk("acc_ovr", 32'(overrun), 0);
      out_ready = 1'b1;
      step(1'b0, 1'b1);

      // Reset mid-frame with buffered word and error pending
      out_ready = 1'b0;
      frame(4'h6, 1'b0);
      frame(4'h7, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      rst = 1'b1;
      step(1'b0, 1'b1);
      rst = 1'b0;
      out_ready = 1'b1;
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_valid", 32'(out_valid), 0);
      chk("mrst_flags", 32'({frame_err, overrun}), 0);
      chk("mrst_data", 32'(out_data), 0);
      frame(4'h9, 1'b1);
      chk("mrst_next", 32'(out_data), 32'h9);

      // Back-to-back frames 0x1 and 0xE
      bits = 12'b1111_0010_0010;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, bits[i]);
         if (out_valid) begin
            qc.push_back(cyc);
            qd.push_back(out_data);
         end
      end
      step(1'b1, 1'b1);
      if (out_valid) qc.push_back(cyc);
      chk("b2b_count", 32'(qc.size()), 2);
      if (qc.size() >= 2) begin
         chk("b2b_gap", 32'(qc[1] - qc[0]), 6);
         b2b = qd[0];
         chk("b2b_d0", 32'(b2b), 32'h1);
         b2b = qd[1];
         chk("b2b_d1", 32'(b2b), 32'hE);
      end

      repeat (2) step(1'b0, 1'b1);
      run = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
